// File: rtl/ttl_74259_sync.sv
// Synchronous 8-bit addressable latch (74259 function) with registered outputs.
// Optional macro TTL_74259_DELAY_EN adds a DELAY_NS transport delay on Q (timing model).
`timescale 1ns / 1ps

module ttl_74259_sync #(
  parameter int WIDTH_SELECT = 3,
  parameter int WIDTH_OUT    = 2 ** WIDTH_SELECT,
  parameter int DELAY_NS     = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    CLRn,
  input  logic                    Gn,
  input  logic [WIDTH_SELECT-1:0] SEL,
  input  logic                    D,
  output logic [WIDTH_OUT-1:0]    Q
);

  logic [WIDTH_OUT-1:0] q_p0;
  logic [WIDTH_OUT-1:0] q_nxt;

  // CLRn=0 zeroes the base, Gn=0 overwrites the addressed bit. The ternary keeps
  // X on SEL/D visible in simulation; out-of-range SEL never matches any bit.
  function automatic logic [WIDTH_OUT-1:0] next_q(
    input logic [WIDTH_OUT-1:0]    cur,
    input logic                    clr_n,
    input logic                    g_n,
    input logic [WIDTH_SELECT-1:0] sel,
    input logic                    d
  );
    logic [WIDTH_OUT-1:0] base;
    logic [WIDTH_OUT-1:0] res;
    base = clr_n ? cur : '0;
    res  = base;
    if (!g_n) begin
      for (int i = 0; i < WIDTH_OUT; i++) begin
        res[i] = (32'(sel) == 32'(i)) ? d : base[i];
      end
    end
    return res;
  endfunction

  always_comb begin
    q_nxt = next_q(q_p0, CLRn, Gn, SEL, D);
  end

  // Stage p0: output register, reset wins over every mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p0 <= '0;
    end else begin
      q_p0 <= q_nxt;
    end
  end

`ifdef TTL_74259_DELAY_EN
  logic [WIDTH_OUT-1:0] q_dly;

  always @(q_p0) begin
    q_dly <= #(DELAY_NS * 1ns) q_p0;
  end

  assign Q = q_dly;
`else
  assign Q = q_p0;
`endif

endmodule

// File: tb/tb_ttl_74259_sync.sv
// Directed self-checking bench for ttl_74259_sync: reset, latch, memory, demux,
// clear, reset mid-sequence and output timing.
`timescale 1ns / 1ps

module tb_ttl_74259_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       CLRn;
  logic       Gn;
  logic [2:0] SEL;
  logic       D;
  logic [7:0] Q;

  int n_tests = 0;
  int n_fail  = 0;

  ttl_74259_sync #(
    .WIDTH_SELECT(3),
    .WIDTH_OUT   (8),
    .DELAY_NS    (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .CLRn (CLRn),
    .Gn   (Gn),
    .SEL  (SEL),
    .D    (D),
    .Q    (Q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    n_tests++;
    assert (Q === exp)
    else begin
      n_fail++;
      $error("FAIL %s: Q=%h expected %h", tag, Q, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
`ifdef TTL_74259_DELAY_EN
    #21;
`else
    #1;
`endif
  endtask

  task automatic drive(input logic r, input logic clr_n, input logic g_n,
                       input logic [2:0] s, input logic d);
    reset = r;
    CLRn  = clr_n;
    Gn    = g_n;
    SEL   = s;
    D     = d;
  endtask

  initial begin
    // Reset held for two edges while a latch write is presented.
    drive(1'b1, 1'b1, 1'b0, 3'd5, 1'b1);
    step();
    chk("reset_edge1", 8'h00);
    step();
    chk("reset_edge2", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
    step();
    chk("reset_release_write", 8'h20);

    // Back to zero, then addressable-latch writes.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    step();
    chk("reset_again", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    chk("latch_sel0", 8'h01);
    drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    step();
    chk("latch_sel3", 8'h09);
    drive(1'b0, 1'b1, 1'b0, 3'd7, 1'b1);
    step();
    chk("latch_sel7", 8'h89);
    drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
    step();
    chk("latch_clr3", 8'h81);

    // No combinational path: input change between edges must not reach Q.
    drive(1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
    #2;
    chk("no_comb_path", 8'h81);

    // Memory mode holds regardless of SEL/D.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 3'(i), i[0]);
      step();
      chk($sformatf("memory_sel%0d", i), 8'h81);
    end

    // Fill to FF, then demux and clear.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), 1'b1);
      step();
    end
    chk("fill_ff", 8'hFF);
    drive(1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
    step();
    chk("demux_sel2", 8'h04);
    drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
    step();
    chk("clear", 8'h00);

    // Demux with D=0 wipes everything.
    drive(1'b0, 1'b1, 1'b0, 3'd7, 1'b1);
    step();
    chk("latch_sel7_b", 8'h80);
    drive(1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    step();
    chk("demux_d0", 8'h00);

    // Reset mid-sequence discards that cycle's write.
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    chk("mid_latch0", 8'h01);
    drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b1);
    step();
    chk("mid_latch2", 8'h05);
    drive(1'b1, 1'b1, 1'b0, 3'd4, 1'b1);
    step();
    chk("mid_reset", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
    step();
    chk("mid_resume", 8'h02);

    // Reset beats memory mode.
    drive(1'b1, 1'b1, 1'b1, 3'd1, 1'b1);
    step();
    chk("reset_over_memory", 8'h00);

    // Output timing of a single write to bit 6.
    drive(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    @(posedge clk);
`ifdef TTL_74259_DELAY_EN
    drive(1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
    #1;
    chk("delay_before_1ns", 8'h00);
    #18;
    chk("delay_before_19ns", 8'h00);
    #2;
    chk("delay_after_21ns", 8'h40);
`else
    #1;
    chk("nodelay_sel6", 8'h40);
    drive(1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
    step();
    chk("nodelay_hold", 8'h40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
